skid_buffer: RTL and testbench

Two-entry valid/ready register slice that breaks both the forward (valid/data) path and the backward (ready) path of a streaming interface. It is the flow-controlled counterpart of the plain one-cycle data register used along our datapaths, and it sits between any producer and consumer that exchange words with a valid/ready handshake. Every output is driven directly from a flop, so no combinational path exists from either side to the other. Full throughput is one word per cycle.

---
 rtl/skid_buffer_pkg.sv | 27 ++
 rtl/skid_buffer_fsm.sv | 80 ++++++++
 rtl/skid_buffer.sv | 53 +++++
 tb/tb_skid_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/skid_buffer_pkg.sv
// Shared constants for the skid buffer: state encoding, occupancy width,
// main-register source select and the state-to-occupancy mapping.
package skid_buffer_pkg;

  localparam logic [1:0] STATE_EMPTY = 2'd0;
  localparam logic [1:0] STATE_BUSY  = 2'd1;
  localparam logic [1:0] STATE_FULL  = 2'd2;

  localparam int COUNT_W = 2;

  typedef enum logic {
    SRC_INPUT = 1'b0,
    SRC_SKID  = 1'b1
  } main_src_e;

  function automatic logic [COUNT_W-1:0] state_count(input logic [1:0] state);
    logic [COUNT_W-1:0] cnt;
    cnt = '0;
    case (state)
      STATE_BUSY: cnt = COUNT_W'(1);
      STATE_FULL: cnt = COUNT_W'(2);
      default:    cnt = '0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/skid_buffer_fsm.sv
// Occupancy controller for the skid buffer. All handshake outputs are flops
// loaded from the next-state value, so neither side sees a combinational path.
//
//   state | meaning
//   EMPTY | no word held, main register invalid
//   BUSY  | one word in main register
//   FULL  | main and skid registers both hold a word, input stalled
module skid_buffer_fsm
  import skid_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  input  logic               m_ready,
  output logic               s_ready,
  output logic               m_valid,
  output logic [COUNT_W-1:0] count,
  output logic               load_main,
  output logic               load_skid,
  output main_src_e          main_src
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       in_xfer;
  logic       out_xfer;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_src  = SRC_INPUT;
    case (state)
      STATE_EMPTY: begin
        if (in_xfer) begin
          state_nxt = STATE_BUSY;
          load_main = 1'b1;
        end
      end
      STATE_BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_nxt = STATE_FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = STATE_EMPTY;
        end
      end
      STATE_FULL: begin
        // s_ready is low here, so only the consumer side can move
        if (out_xfer) begin
          state_nxt = STATE_BUSY;
          load_main = 1'b1;
          main_src  = SRC_SKID;
        end
      end
      default: state_nxt = STATE_EMPTY;
    endcase
  end

  // s_ready resets low and rises on the first edge after reset releases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= STATE_EMPTY;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt != STATE_FULL);
      m_valid <= (state_nxt != STATE_EMPTY);
      count   <= state_count(state_nxt);
    end
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice: main register drives m_data, skid
// register catches the one word that arrives while backpressure propagates.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic [COUNT_W-1:0] count
);

  logic             load_main;
  logic             load_skid;
  main_src_e        main_src;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] main_d;

  skid_buffer_fsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .m_ready   (m_ready),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .count     (count),
    .load_main (load_main),
    .load_skid (load_skid),
    .main_src  (main_src)
  );

  assign main_d = (main_src == SRC_SKID) ? skid_q : s_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_d;
      if (load_skid) skid_q <= s_data;
    end
  end

  assign m_data = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: accepted words are queued by an occupancy
// model and popped by the output monitor on every consumer transfer.
module tb_skid_buffer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cnt = 0;
  bit           exp_sready = 1'b0;
  bit           acc_flag = 1'b0;
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;

  skid_buffer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model and monitor run on the falling edge, predicting the next rising edge.
  always @(negedge clk) begin
    bit in_x;
    bit out_x;
    if (reset) begin
      exp_q.delete();
      exp_cnt    = 0;
      exp_sready = 1'b0;
      acc_flag   = 1'b0;
      prev_hold  = 1'b0;
      check("rst_s_ready", 32'(s_ready), 32'(0));
      check("rst_m_valid", 32'(m_valid), 32'(0));
      check("rst_count", 32'(count), 32'(0));
      check("rst_m_data", 32'(m_data), 32'(0));
    end else begin
      check("s_ready", 32'(s_ready), 32'(exp_sready));
      check("m_valid", 32'(m_valid), 32'(exp_cnt != 0));
      check("count", 32'(count), 32'(exp_cnt));
      if (prev_hold && m_valid) check("m_data_stable", 32'(m_data), 32'(prev_data));
      out_x = m_ready && (exp_cnt != 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_data_order actual=%0h required=none (unexpected word)", m_data);
        end else begin
          check("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      in_x = s_valid && exp_sready;
      if (in_x) exp_q.push_back(s_data);
      acc_flag   = in_x;
      exp_cnt    = exp_cnt + int'(in_x) - int'(out_x);
      exp_sready = (exp_cnt != 2);
      prev_hold  = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic cyc(input bit v, input logic [W-1:0] d, input bit r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pend;

    // Power-on reset with a producer already offering a word
    s_valid = 1'b1;
    s_data  = 32'h99;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, 32'h99, 1'b1);
    check("first_edge_s_ready", 32'(s_ready), 32'(1));
    check("first_edge_m_valid", 32'(m_valid), 32'(0));
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);

    // Reset asserted mid-cycle while holding one word
    cyc(1'b1, 32'h77, 1'b0);
    s_valid = 1'b1;
    reset   = 1'b1;
    #2;
    check("async_s_ready", 32'(s_ready), 32'(0));
    check("async_m_valid", 32'(m_valid), 32'(0));
    check("async_count", 32'(count), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 32'h0, 1'b1);
    check("post_rst_s_ready", 32'(s_ready), 32'(1));
    cyc(1'b0, 32'h0, 1'b1);

    // Back-to-back streaming
    for (int i = 1; i <= 16; i++) cyc(1'b1, W'(i), 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);

    // Stall then drain
    cyc(1'b1, 32'hA1, 1'b0);
    check("stall_count1", 32'(count), 32'(1));
    cyc(1'b1, 32'hA2, 1'b0);
    check("stall_count2", 32'(count), 32'(2));
    check("stall_s_ready", 32'(s_ready), 32'(0));
    cyc(1'b1, 32'hA3, 1'b0);
    cyc(1'b1, 32'hA3, 1'b0);
    check("stall_m_data", 32'(m_data), 32'hA1);
    cyc(1'b1, 32'hA3, 1'b1);
    check("drain_s_ready", 32'(s_ready), 32'(1));
    check("drain_m_data", 32'(m_data), 32'hA2);
    cyc(1'b1, 32'hA3, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'(0));

    // Reset while full discards both words
    cyc(1'b1, 32'hB1, 1'b0);
    cyc(1'b1, 32'hB2, 1'b0);
    check("full_count", 32'(count), 32'(2));
    s_valid = 1'b1;
    s_data  = 32'h55;
    reset   = 1'b1;
    #2;
    check("full_rst_count", 32'(count), 32'(0));
    check("full_rst_m_data", 32'(m_data), 32'(0));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, 32'h55, 1'b1);
    cyc(1'b1, 32'h55, 1'b1);
    check("first_after_rst", 32'(m_data), 32'h55);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);

    // Random valid/ready traffic; producer holds an unaccepted word
    pend = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!(pend && !acc_flag)) begin
        pend   = ($urandom_range(0, 1) == 1);
        s_data = $urandom;
      end
      s_valid = pend;
      m_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1);
    check("random_drained", 32'(exp_q.size()), 32'(0));
    check("random_count", 32'(count), 32'(0));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
